instr_encoder: RTL and testbench

Sequential ADDI instruction encoder and instruction-memory loader; it is the encoding counterpart of the core's control decoder. It accepts register/immediate field descriptions over a valid/ready stream and packs each into a 32-bit I-type ADDI word (opcode 0010011, funct3 000). It buffers the words in a 2-entry FIFO and writes them to consecutive word addresses of instruction memory through a backpressured write port. It sits between the bring-up/test host and the instruction memory, and loads programs before the core is released.

---
 rtl/instr_encoder_if.sv | 26 ++
 rtl/instr_encoder.sv | 90 +++++++++
 tb/tb_instr_encoder.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Descriptor stream and instruction-memory write port of instr_encoder.
// slave is the encoder's view; master is the host/memory environment.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [11:0]       in_imm12;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;

    modport slave (
        input  in_valid, in_rd, in_rs1, in_imm12, in_last, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_rd, in_rs1, in_imm12, in_last, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// ADDI encoder: packs rd/rs1/imm12 descriptors into I-type words, buffers them
// in a 2-entry FIFO and writes them to consecutive instruction-memory words.
module instr_encoder #(
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    instr_encoder_if.slave    bus,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [31:0]       fifo_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wrapped_q;
    logic              err_q;

    logic              push, pop, empty;
    logic [ADDR_W-1:0] addr_inc;
    logic [31:0]       word;

    assign empty    = (cnt_q == 2'd0);
    assign word     = {bus.in_imm12, bus.in_rs1, 3'b000, bus.in_rd, 7'b0010011};
    assign addr_inc = addr_q + ADDR_W'(3'd4);

    assign bus.in_ready  = (state_q == S_LOAD) && (cnt_q != 2'd2);
    assign bus.mem_we    = (state_q != S_IDLE) && !empty;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = fifo_q[rd_ptr_q];

    assign push   = bus.in_valid && bus.in_ready;
    assign pop    = bus.mem_we && bus.mem_ready;
    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_DONE);
    assign err_o  = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_LOAD;
            S_LOAD:  if (push && bus.in_last) state_d = S_FLUSH;
            // Leave on the edge that writes the last word so done follows it directly.
            S_FLUSH: if (empty || (cnt_q == 2'd1 && pop)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < 2; i++) fifo_q[i] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= '0;
            addr_q    <= BASE_ADDR;
            wrapped_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= word;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            if (push && !pop)      cnt_q <= cnt_q + 2'd1;
            else if (!push && pop) cnt_q <= cnt_q - 2'd1;

            if (state_q == S_IDLE && start_i) begin
                addr_q    <= BASE_ADDR;
                wrapped_q <= 1'b0;
                err_q     <= 1'b0;
            end else if (pop) begin
                addr_q <= addr_inc;
                if (addr_inc == '0) wrapped_q <= 1'b1;
                if (wrapped_q)      err_q     <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed literal cases plus randomized programs
// compared every cycle against a queue-based model of the loader.
module tb_instr_encoder;
    localparam int unsigned       AW   = 4;
    localparam logic [AW-1:0]     BASE = '0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_i = 1'b0;
    logic busy_o, done_o, err_o;
    int   n_tests = 0;
    int   n_fail = 0;

    instr_encoder_if #(.ADDR_W(AW)) bus();

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start_i),
        .bus     (bus),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 accepting, 2 draining, 3 finished.
    logic [31:0] mq[$];
    int          m_phase = 0;
    int unsigned m_addr = 0;
    bit          m_wrapped = 0;
    bit          m_err = 0;

    function automatic logic [31:0] encode(input int unsigned rd, input int unsigned rs1,
                                           input int unsigned imm);
        return 32'(imm * 32'h0010_0000 + rs1 * 32'h8000 + rd * 128 + 19);
    endfunction

    function automatic bit m_in_ready();
        return (m_phase == 1) && (mq.size() < 2);
    endfunction

    function automatic bit m_we();
        return (m_phase != 0) && (mq.size() > 0);
    endfunction

    initial forever begin
        bit acc, xfer;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_phase = 0; m_addr = BASE; m_wrapped = 0; m_err = 0;
        end else begin
            acc  = m_in_ready() && bus.in_valid;
            xfer = m_we() && bus.mem_ready;
            if (xfer) begin
                void'(mq.pop_front());
                if (m_wrapped) m_err = 1;
                m_addr = (m_addr + 4) % (1 << AW);
                if (m_addr == 0) m_wrapped = 1;
            end
            if (acc) mq.push_back(encode(bus.in_rd, bus.in_rs1, bus.in_imm12));
            case (m_phase)
                0: if (start_i) begin
                       m_phase = 1; m_addr = BASE; m_wrapped = 0; m_err = 0;
                   end
                1: if (acc && bus.in_last) m_phase = 2;
                2: if (mq.size() == 0) m_phase = 3;
                default: m_phase = 0;
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("in_ready", 32'(bus.in_ready), 32'(m_in_ready()));
            chk("mem_we",   32'(bus.mem_we),   32'(m_we()));
            chk("mem_addr", 32'(bus.mem_addr), m_addr);
            if (m_we()) chk("mem_wdata", bus.mem_wdata, mq[0]);
            chk("busy", 32'(busy_o), 32'(m_phase != 0));
            chk("done", 32'(done_o), 32'(m_phase == 3));
            chk("err",  32'(err_o),  32'(m_err));
        end
    end

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic put(input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [11:0] imm, input logic last);
        bus.in_valid = 1'b1; bus.in_rd = rd; bus.in_rs1 = rs1;
        bus.in_imm12 = imm;  bus.in_last = last;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int guard = 0;
        while (!done_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk(name, 32'(done_o), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int ea[5];
        int ndone;
        bus.in_valid = 1'b0; bus.in_rd = '0; bus.in_rs1 = '0;
        bus.in_imm12 = '0;   bus.in_last = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy",  32'(busy_o),        32'd0);
        chk("rst_we",    32'(bus.mem_we),    32'd0);
        chk("rst_ready", 32'(bus.in_ready),  32'd0);
        chk("rst_addr",  32'(bus.mem_addr),  32'(BASE));
        chk("rst_wdata", bus.mem_wdata,      32'd0);

        // Single word, then negative immediate
        bus.mem_ready = 1'b1;
        pulse_start();
        put(5'd1, 5'd0, 12'd5, 1'b1);
        chk("w1_we",   32'(bus.mem_we),   32'd1);
        chk("w1_addr", 32'(bus.mem_addr), 32'h0);
        chk("w1_data", bus.mem_wdata,     32'h0050_0093);
        @(negedge clk);
        chk("w1_done", 32'(done_o), 32'd1);
        @(negedge clk);
        chk("w1_done_off", 32'(done_o), 32'd0);
        chk("w1_busy_off", 32'(busy_o), 32'd0);

        pulse_start();
        put(5'd2, 5'd2, 12'hFFF, 1'b1);
        chk("neg_addr", 32'(bus.mem_addr), 32'h0);
        chk("neg_data", bus.mem_wdata,     32'hFFF1_0113);
        wait_done("neg_done");

        // Five-word stream at full rate: address wraps and err rises on the 5th write
        ea = '{0, 4, 8, 12, 0};
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            chk("strm_ready", 32'(bus.in_ready), 32'd1);
            put(5'(i + 1), 5'(i), 12'(i * 3), i == 4);
            chk("strm_we",   32'(bus.mem_we),   32'd1);
            chk("strm_addr", 32'(bus.mem_addr), 32'(ea[i]));
        end
        @(negedge clk);
        chk("wrap_done", 32'(done_o), 32'd1);
        chk("wrap_err",  32'(err_o),  32'd1);
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_o) ndone++;
        end
        chk("single_done", 32'(ndone), 32'd0);
        chk("err_sticky",  32'(err_o), 32'd1);
        pulse_start();
        chk("err_clear", 32'(err_o), 32'd0);
        bus.mem_ready = 1'b0;

        // Backpressure: two words buffered, memory stalled for 3 cycles
        put(5'd3, 5'd4, 12'h123, 1'b0);
        put(5'd5, 5'd6, 12'h456, 1'b0);
        repeat (3) begin
            chk("bp_ready", 32'(bus.in_ready),  32'd0);
            chk("bp_addr",  32'(bus.mem_addr),  32'h0);
            chk("bp_data",  bus.mem_wdata,      32'h1232_0193);
            @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_rel_addr",  32'(bus.mem_addr), 32'h4);
        chk("bp_rel_data",  bus.mem_wdata,     encode(5, 6, 'h456));
        put(5'd7, 5'd8, 12'd9, 1'b1);
        chk("bp_last_addr", 32'(bus.mem_addr), 32'h8);
        chk("bp_last_data", bus.mem_wdata,     encode(7, 8, 9));
        wait_done("bp_done");

        // Asynchronous reset with two words buffered
        bus.mem_ready = 1'b0;
        pulse_start();
        put(5'd9, 5'd10, 12'hABC, 1'b0);
        put(5'd11, 5'd12, 12'hDEF, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ready", 32'(bus.in_ready), 32'd0);
        chk("ar_we",    32'(bus.mem_we),   32'd0);
        chk("ar_addr",  32'(bus.mem_addr), 32'(BASE));
        chk("ar_wdata", bus.mem_wdata,     32'd0);
        chk("ar_busy",  32'(busy_o),       32'd0);
        chk("ar_done",  32'(done_o),       32'd0);
        chk("ar_err",   32'(err_o),        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("ar_idle_we",   32'(bus.mem_we), 32'd0);
            chk("ar_idle_busy", 32'(busy_o),     32'd0);
        end

        // Randomized programs with random valid, memory stalls and stray starts
        for (int p = 0; p < 25; p++) begin
            int n, idx, guard;
            n = $urandom_range(9, 1);
            pulse_start();
            idx = 0; guard = 0;
            while (idx < n && guard < 400) begin
                bus.mem_ready = ($urandom % 4) != 0;
                bus.in_valid  = ($urandom % 3) != 0;
                bus.in_rd     = 5'($urandom);
                bus.in_rs1    = 5'($urandom);
                bus.in_imm12  = 12'($urandom);
                bus.in_last   = (idx == n - 1);
                start_i       = ($urandom % 8) == 0;
                if (bus.in_valid && bus.in_ready) idx++;
                @(negedge clk);
                guard++;
            end
            chk("rnd_accept_all", 32'(idx), 32'(n));
            bus.in_valid = 1'b0; bus.in_last = 1'b0; start_i = 1'b0;
            guard = 0;
            while (!done_o && guard < 200) begin
                bus.mem_ready = ($urandom % 2) != 0;
                @(negedge clk);
                guard++;
            end
            chk("rnd_done", 32'(done_o), 32'd1);
            bus.mem_ready = 1'b1;
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
